// File: rtl/pwm_decoder_if.sv
// PWM decoder bus: control/sample inputs and published measurement outputs.
// Master drives the controls and the PWM input; slave is the decoder.
interface pwm_decoder_if #(
  parameter int N = 8
);
  logic       ena;
  logic       step;
  logic       pwm_in;
  logic [N:0] high_time;
  logic [N:0] period;
  logic       level;
  logic       valid;

  modport master (
    output ena,
    output step,
    output pwm_in,
    input  high_time,
    input  period,
    input  level,
    input  valid
  );

  modport slave (
    input  ena,
    input  step,
    input  pwm_in,
    output high_time,
    output period,
    output level,
    output valid
  );
endinterface

// File: rtl/pwm_decoder.sv
// Measures high time and period of an asynchronous PWM input in step units.
// Publishes on each rising edge, or a constant level when the counter saturates.
module pwm_decoder #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  pwm_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE
  } state_e;

  localparam logic [N:0] CMAX = '1;
  localparam logic [N:0] ONE  = {{N{1'b0}}, 1'b1};

  logic [1:0] sync_q;
  logic       prev_q, prev_d;
  state_e     state_q, state_d;
  logic [N:0] cnt_q, cnt_d;
  logic [N:0] hcnt_q, hcnt_d;
  logic [N:0] ht_q, ht_d;
  logic [N:0] per_q, per_d;
  logic       lvl_q, lvl_d;
  logic       valid_q, valid_d;

  logic       s;
  logic       rise;
  logic [N:0] cnt_inc;
  logic [N:0] hcnt_inc;

  assign s        = sync_q[1];
  assign rise     = bus.step & s & ~prev_q;
  assign cnt_inc  = (cnt_q == CMAX) ? cnt_q : cnt_q + ONE;
  assign hcnt_inc = (hcnt_q == CMAX) ? hcnt_q : hcnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    prev_d  = prev_q;
    ht_d    = ht_q;
    per_d   = per_q;
    lvl_d   = lvl_q;
    valid_d = 1'b0;

    if (bus.step) prev_d = s;

    if (!bus.ena) begin
      state_d = WAIT_LOW;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else if (bus.step) begin
      // saturated counter with no edge: the input is constant
      if (!rise && cnt_q == CMAX) begin
        ht_d    = '0;
        per_d   = '0;
        lvl_d   = s;
        valid_d = 1'b1;
        cnt_d   = '0;
        hcnt_d  = '0;
        state_d = s ? WAIT_LOW : WAIT_RISE;
      end else begin
        unique case (state_q)
          WAIT_LOW: begin
            cnt_d = cnt_inc;
            if (!s) state_d = WAIT_RISE;
          end
          WAIT_RISE: begin
            cnt_d = cnt_inc;
            if (s) begin
              state_d = MEASURE;
              cnt_d   = ONE;
              hcnt_d  = ONE;
            end
          end
          MEASURE: begin
            if (rise) begin
              ht_d    = hcnt_q;
              per_d   = cnt_q;
              lvl_d   = 1'b0;
              valid_d = 1'b1;
              cnt_d   = ONE;
              hcnt_d  = ONE;
            end else begin
              cnt_d = cnt_inc;
              if (s) hcnt_d = hcnt_inc;
            end
          end
          default: state_d = WAIT_LOW;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      state_q <= WAIT_LOW;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      ht_q    <= '0;
      per_q   <= '0;
      lvl_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.pwm_in};
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      ht_q    <= ht_d;
      per_q   <= per_d;
      lvl_q   <= lvl_d;
      valid_q <= valid_d;
    end
  end

  assign bus.high_time = ht_q;
  assign bus.period    = per_q;
  assign bus.level     = lvl_q;
  assign bus.valid     = valid_q;

endmodule
